rv32i_run_ctrl: RTL and testbench
=================================

# rv32i_run_ctrl

Synthesizable run controller for the rv32i core, replacing the fixed-duration, single-register testbench harness. It holds the core in reset and then releases it, counts cycles, and detects program halt as a PC self-loop. It snoops register-file writebacks into NWATCH shadow channels and compares them against expected values, producing a pass/fail verdict. It sits between the bench (or a board-level host) and `rv32i`, driving the core's reset and run-enable.

## Interface
Parameters:
- `XLEN`, 32, data and PC width
- `NWATCH`, 4, number of watched register channels (1..8)
- `CNT_W`, 16, cycle counter and limit width
- `HALT_STABLE`, 2, consecutive cycles with an unchanged PC that declare a halt (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: begin a run; sampled in IDLE or DONE
- `cycle_limit` in CNT_W: RUN-cycle budget; 0 = unlimited
- `pc` in XLEN: core's current PC
- `rd_we` in 1: core register-file write enable
- `rd_addr` in 5: core writeback register index
- `rd_data` in XLEN: core writeback data
- `watch_addr` in NWATCH*5: register index per channel (channel i at bits [5i+4:5i])
- `expect_data` in NWATCH*XLEN: expected final value per channel
- `expect_mask` in NWATCH: 1 = channel participates in the verdict
- `core_rst_n` out 1: active-low reset to the core
- `core_run` out 1: core clock-enable / run
- `busy` out 1: in RESET_CORE, RUN or CHECK
- `done` out 1: in DONE
- `pass` out 1: verdict, valid while `done`
- `timeout` out 1: run ended on the budget, valid while `done`
- `cycles` out CNT_W: RUN cycles elapsed
- `watch_val` out NWATCH*XLEN: shadow values
- `mismatch` out NWATCH: per-channel compare failure (masked), valid while `done`

## Operation
- States: IDLE, RESET_CORE, RUN, CHECK, DONE.
- IDLE:
  - `core_rst_n`=0, `core_run`=0.
  - `start`=1 → RESET_CORE.
- RESET_CORE (exactly 2 cycles):
  - `core_rst_n`=0.
  - Clears `cycles`, shadows, stable counter, `pass`, `timeout` and `mismatch`.
  - Then → RUN.
- RUN:
  - `core_rst_n`=1, `core_run`=1.
  - `cycles` increments by 1 every cycle and saturates at all-ones.
  - Stable counter increments when `pc` equals the registered previous `pc`; otherwise it resets to 0.
  - Halt when the stable counter reaches HALT_STABLE.
  - Timeout when the incremented `cycles` equals `cycle_limit` (limit ≠ 0).
  - Either condition → CHECK.
  - Halt and limit in the same cycle: halt wins, `timeout`=0.
- Shadow capture (RUN only):
  - Channel i loads `rd_data` when `rd_we` && `rd_addr`==`watch_addr[i]` && `rd_addr`≠0.
  - Multiple channels with the same index all capture.
  - A channel watching x0 stays 0.
  - A write in the final RUN cycle is captured.
- CHECK (1 cycle):
  - `core_run`=0; `core_rst_n` stays 1, so core state is preserved for inspection.
  - `mismatch[i]` = `expect_mask[i]` && (shadow ≠ expected).
  - `pass` = no mismatch && !timeout.
  - Then → DONE.
- DONE:
  - Holds the verdict, shadows and `cycles`.
  - `start` → RESET_CORE (restart).
- `rst_n` low at any time (asynchronous): state → IDLE, all registers cleared, `core_rst_n`=0 immediately.

## Timing
- Reset values:
  - `core_rst_n`=0, `core_run`=0, `busy`=0, `done`=0, `pass`=0, `timeout`=0.
  - `cycles`=0, `watch_val`=0, `mismatch`=0.
- `start` seen at edge T:
  - RESET_CORE for T+1 and T+2.
  - RUN from T+3, so the first core instruction executes in cycle T+3.
- Halt latency: with `pc` first repeating in RUN cycle k, the stable counter hits HALT_STABLE at cycle k+HALT_STABLE−1; CHECK follows on the next cycle, and `done`=1 one cycle after CHECK.
- Inputs `cycle_limit`, `watch_addr`, `expect_data`, `expect_mask` must be stable from `start` through DONE; they are not registered.
- `start` held high in DONE restarts every time; `start` while `busy` is ignored.
- All outputs are registered except `core_run` and `core_rst_n`, which are state decodes.

## Test plan
- **Normal halt.** Program writes x1=0x0000_0005, then `jal x0,0`; `watch_addr[0]`=1, expect 5, mask 0001, limit 100 → `done`, `pass`=1, `timeout`=0, `watch_val[0]`=5, `cycles` = instructions + HALT_STABLE.
- **Mismatch.** Same program, expect x1=6 → `pass`=0, `mismatch`=0001.
- **Timeout.** Infinite loop alternating two PCs, limit 20 → CHECK after exactly 20 RUN cycles, `timeout`=1, `pass`=0, `cycles`=20.
- **Tie-break and x0.** Halt on the same cycle as the limit → `timeout`=0. Channel watching x0 with expect 0 passes despite `rd_we` to x0.
- **Reset mid-run.** `rst_n` pulsed low in RUN → `core_rst_n`=0 that same cycle, all outputs return to reset values, IDLE; a following `start` completes normally.
- **Restart from DONE.** `start` in DONE → shadows and `cycles` cleared, 2-cycle core reset, identical verdict on rerun.

Source files
------------

// File: rtl/rv32i_run_ctrl_if.sv
// Run-controller bundle: host-side run control and verdict, plus the core-side
// snoop signals (PC and register-file writeback) and the core reset/run drives.
interface rv32i_run_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int NWATCH = 4,
    parameter int CNT_W  = 16
) ();
    logic                     start;
    logic [CNT_W-1:0]         cycle_limit;
    logic [XLEN-1:0]          pc;
    logic                     rd_we;
    logic [4:0]               rd_addr;
    logic [XLEN-1:0]          rd_data;
    logic [NWATCH*5-1:0]      watch_addr;
    logic [NWATCH*XLEN-1:0]   expect_data;
    logic [NWATCH-1:0]        expect_mask;
    logic                     core_rst_n;
    logic                     core_run;
    logic                     busy;
    logic                     done;
    logic                     pass;
    logic                     timeout;
    logic [CNT_W-1:0]         cycles;
    logic [NWATCH*XLEN-1:0]   watch_val;
    logic [NWATCH-1:0]        mismatch;

    modport master (
        output start, cycle_limit, pc, rd_we, rd_addr, rd_data,
               watch_addr, expect_data, expect_mask,
        input  core_rst_n, core_run, busy, done, pass, timeout,
               cycles, watch_val, mismatch
    );

    modport slave (
        input  start, cycle_limit, pc, rd_we, rd_addr, rd_data,
               watch_addr, expect_data, expect_mask,
        output core_rst_n, core_run, busy, done, pass, timeout,
               cycles, watch_val, mismatch
    );
endinterface

// File: rtl/rv32i_run_ctrl.sv
// rv32i run controller: holds the core in reset for two cycles, lets it run,
// detects halt as a PC self-loop (or stops on a cycle budget), snoops
// register writebacks into shadow channels and produces a pass/fail verdict.
module rv32i_run_ctrl #(
    parameter int XLEN        = 32,
    parameter int NWATCH      = 4,
    parameter int CNT_W       = 16,
    parameter int HALT_STABLE = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    rv32i_run_ctrl_if.slave bus
);
    localparam int ST_W = $clog2(HALT_STABLE + 1);
    localparam int WV_W = NWATCH * XLEN;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RESET_CORE = 3'd1,
        ST_RUN        = 3'd2,
        ST_CHECK      = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic               rst_cnt_r;
    logic [CNT_W-1:0]   cycles_r;
    logic [CNT_W-1:0]   cycles_inc_s;
    logic [XLEN-1:0]    prev_pc_r;
    logic               prev_vld_r;
    logic [ST_W-1:0]    stable_r;
    logic [ST_W-1:0]    stable_nx_s;
    logic               halt_s;
    logic               limit_s;
    logic [WV_W-1:0]    shadow_r;
    logic [WV_W-1:0]    shadow_nx_s;
    logic [NWATCH-1:0]  mismatch_r;
    logic [NWATCH-1:0]  mismatch_nx_s;
    logic               pass_r;
    logic               timeout_r;
    logic               busy_r;
    logic               done_r;

    // Cycle counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    // Run-phase conditions: saturating count, PC-stability window, halt and budget.
    always_comb begin
        cycles_inc_s = sat_inc(cycles_r);
        stable_nx_s  = {ST_W{1'b0}};
        if (prev_vld_r && (bus.pc == prev_pc_r)) begin
            stable_nx_s = stable_r + ST_W'(1);
        end else begin
            stable_nx_s = {ST_W{1'b0}};
        end
        halt_s  = (stable_nx_s >= ST_W'(HALT_STABLE));
        limit_s = (bus.cycle_limit != {CNT_W{1'b0}}) && (cycles_inc_s == bus.cycle_limit);
    end

    // Shadow capture and per-channel compare against the expected values.
    always_comb begin
        shadow_nx_s   = shadow_r;
        mismatch_nx_s = {NWATCH{1'b0}};
        for (int i = 0; i < NWATCH; i++) begin
            // x0 writes never land, so a channel watching x0 stays zero.
            if (bus.rd_we && (bus.rd_addr != 5'd0) && (bus.rd_addr == bus.watch_addr[5*i +: 5])) begin
                shadow_nx_s[XLEN*i +: XLEN] = bus.rd_data;
            end else begin
                shadow_nx_s[XLEN*i +: XLEN] = shadow_r[XLEN*i +: XLEN];
            end
            mismatch_nx_s[i] = bus.expect_mask[i] &&
                               (shadow_r[XLEN*i +: XLEN] != bus.expect_data[XLEN*i +: XLEN]);
        end
    end

    // Next-state logic of the run sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx_s = ST_RESET_CORE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RESET_CORE: begin
                if (rst_cnt_r) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_RESET_CORE;
                end
            end
            ST_RUN: begin
                if (halt_s || limit_s) begin
                    state_nx_s = ST_CHECK;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_CHECK: begin
                state_nx_s = ST_DONE;
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_nx_s = ST_RESET_CORE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Two-cycle core-reset timer: toggles once per RESET_CORE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_cnt_r <= 1'b0;
        end else if (state_r == ST_RESET_CORE) begin
            rst_cnt_r <= ~rst_cnt_r;
        end else begin
            rst_cnt_r <= 1'b0;
        end
    end

    // Run datapath: cycle count, PC history and shadows; cleared on entry to core reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_r   <= {CNT_W{1'b0}};
            prev_pc_r  <= {XLEN{1'b0}};
            prev_vld_r <= 1'b0;
            stable_r   <= {ST_W{1'b0}};
            shadow_r   <= {WV_W{1'b0}};
        end else if (state_nx_s == ST_RESET_CORE) begin
            cycles_r   <= {CNT_W{1'b0}};
            prev_pc_r  <= {XLEN{1'b0}};
            prev_vld_r <= 1'b0;
            stable_r   <= {ST_W{1'b0}};
            shadow_r   <= {WV_W{1'b0}};
        end else if (state_r == ST_RUN) begin
            cycles_r   <= cycles_inc_s;
            prev_pc_r  <= bus.pc;
            prev_vld_r <= 1'b1;
            stable_r   <= stable_nx_s;
            shadow_r   <= shadow_nx_s;
        end else begin
            cycles_r   <= cycles_r;
            prev_pc_r  <= prev_pc_r;
            prev_vld_r <= prev_vld_r;
            stable_r   <= stable_r;
            shadow_r   <= shadow_r;
        end
    end

    // Verdict: timeout latched at the end of RUN (halt wins a tie), compare in CHECK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_r  <= 1'b0;
            pass_r     <= 1'b0;
            mismatch_r <= {NWATCH{1'b0}};
        end else if (state_nx_s == ST_RESET_CORE) begin
            timeout_r  <= 1'b0;
            pass_r     <= 1'b0;
            mismatch_r <= {NWATCH{1'b0}};
        end else if (state_r == ST_RUN) begin
            timeout_r  <= limit_s && !halt_s;
            pass_r     <= 1'b0;
            mismatch_r <= {NWATCH{1'b0}};
        end else if (state_r == ST_CHECK) begin
            timeout_r  <= timeout_r;
            pass_r     <= (mismatch_nx_s == {NWATCH{1'b0}}) && !timeout_r;
            mismatch_r <= mismatch_nx_s;
        end else begin
            timeout_r  <= timeout_r;
            pass_r     <= pass_r;
            mismatch_r <= mismatch_r;
        end
    end

    // Registered status flags, aligned with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s == ST_RESET_CORE) || (state_nx_s == ST_RUN) ||
                      (state_nx_s == ST_CHECK);
            done_r <= (state_nx_s == ST_DONE);
        end
    end

    // Core controls decode straight from state so an async reset drops them at once;
    // the core stays out of reset after the run so its state can be inspected.
    assign bus.core_run   = (state_r == ST_RUN);
    assign bus.core_rst_n = (state_r == ST_RUN) || (state_r == ST_CHECK) || (state_r == ST_DONE);
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.pass       = pass_r;
    assign bus.timeout    = timeout_r;
    assign bus.cycles     = cycles_r;
    assign bus.watch_val  = shadow_r;
    assign bus.mismatch   = mismatch_r;
endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// Bench for rv32i_run_ctrl: a trace-playing core stand-in, a reference model
// over PC/writeback traces, and a scoreboard checked whenever done rises.
module tb_rv32i_run_ctrl;
    localparam int XLEN   = 32;
    localparam int NWATCH = 4;
    localparam int CNT_W  = 16;
    localparam int HS     = 2;
    localparam int WV_W   = NWATCH * XLEN;

    typedef struct {
        int                cyc;
        logic              to;
        logic              ps;
        logic [NWATCH-1:0] mm;
        logic [WV_W-1:0]   wv;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sbq[$];
    logic [XLEN-1:0] tr_pc[$];
    logic            tr_we[$];
    logic [4:0]      tr_addr[$];
    logic [XLEN-1:0] tr_data[$];
    int   ridx;
    int   run_cnt;
    int   since_run;
    logic done_q;

    rv32i_run_ctrl_if #(.XLEN(XLEN), .NWATCH(NWATCH), .CNT_W(CNT_W)) bus ();

    rv32i_run_ctrl #(.XLEN(XLEN), .NWATCH(NWATCH), .CNT_W(CNT_W), .HALT_STABLE(HS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chkw(input string name, input logic [WV_W-1:0] act, input logic [WV_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string p);
        chkb({p, "_core_rst_n"}, bus.core_rst_n, 1'b0);
        chkb({p, "_core_run"}, bus.core_run, 1'b0);
        chkb({p, "_busy"}, bus.busy, 1'b0);
        chkb({p, "_done"}, bus.done, 1'b0);
        chkb({p, "_pass"}, bus.pass, 1'b0);
        chkb({p, "_timeout"}, bus.timeout, 1'b0);
        chkw({p, "_cycles"}, WV_W'(bus.cycles), '0);
        chkw({p, "_watch_val"}, bus.watch_val, '0);
        chkw({p, "_mismatch"}, WV_W'(bus.mismatch), '0);
    endtask

    task automatic tr_clear();
        tr_pc.delete(); tr_we.delete(); tr_addr.delete(); tr_data.delete();
    endtask

    task automatic tr_add(input logic [XLEN-1:0] p, input logic we, input logic [4:0] a,
                          input logic [XLEN-1:0] d);
        tr_pc.push_back(p); tr_we.push_back(we); tr_addr.push_back(a); tr_data.push_back(d);
    endtask

    task automatic set_ch(input int ch, input logic [4:0] a, input logic [XLEN-1:0] d);
        bus.watch_addr[5*ch +: 5]        = a;
        bus.expect_data[XLEN*ch +: XLEN] = d;
    endtask

    // PC seen in RUN cycle n (1-based); after the trace the core sits on its last PC.
    function automatic logic [XLEN-1:0] pc_at(input int n);
        if (n - 1 < tr_pc.size()) pc_at = tr_pc[n-1];
        else pc_at = tr_pc[tr_pc.size()-1];
    endfunction

    // Reference: walk RUN cycles until the last HS+1 PCs agree or the budget is hit.
    function automatic exp_t model();
        exp_t e;
        logic [XLEN-1:0] sh [NWATCH];
        int  n;
        bit  fin;
        bit  halt;
        e.to = 1'b0; e.ps = 1'b0; e.mm = '0; e.wv = '0; e.cyc = 0;
        for (int i = 0; i < NWATCH; i++) sh[i] = '0;
        n = 0; fin = 1'b0;
        while (!fin && n < 5000) begin
            n++;
            if (n - 1 < tr_pc.size()) begin
                if (tr_we[n-1] && tr_addr[n-1] != 5'd0) begin
                    for (int i = 0; i < NWATCH; i++)
                        if (bus.watch_addr[5*i +: 5] == tr_addr[n-1]) sh[i] = tr_data[n-1];
                end
            end
            halt = (n > HS);
            if (halt) begin
                for (int j = 1; j <= HS; j++)
                    if (pc_at(n - j) != pc_at(n)) halt = 1'b0;
            end
            if (halt) fin = 1'b1;
            else if (bus.cycle_limit != '0 && n == int'(bus.cycle_limit)) begin
                fin = 1'b1; e.to = 1'b1;
            end
        end
        e.cyc = n;
        for (int i = 0; i < NWATCH; i++) begin
            e.wv[XLEN*i +: XLEN] = sh[i];
            e.mm[i] = bus.expect_mask[i] && (sh[i] != bus.expect_data[XLEN*i +: XLEN]);
        end
        e.ps = (e.mm == '0) && !e.to;
        return e;
    endfunction

    // Core stand-in: one trace entry per RUN cycle, driven just after the edge.
    initial begin
        bus.pc = '0; bus.rd_we = 1'b0; bus.rd_addr = '0; bus.rd_data = '0; ridx = 0;
        forever begin
            @(posedge clk); #1;
            if (bus.core_run) begin
                if (ridx < tr_pc.size()) begin
                    bus.pc = tr_pc[ridx]; bus.rd_we = tr_we[ridx];
                    bus.rd_addr = tr_addr[ridx]; bus.rd_data = tr_data[ridx];
                end else begin
                    bus.pc = tr_pc[tr_pc.size()-1]; bus.rd_we = 1'b0;
                end
                ridx++;
            end else begin
                ridx = 0; bus.rd_we = 1'b0;
            end
        end
    end

    // Monitor: count RUN cycles and check the scoreboard head each time done rises.
    initial begin
        exp_t e;
        run_cnt = 0; since_run = 0; done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || (bus.busy && !bus.core_rst_n)) begin
                run_cnt = 0; since_run = 0;
            end else if (bus.core_run) begin
                run_cnt++; since_run = 0;
            end else begin
                since_run++;
            end
            if (bus.done && !done_q) begin
                if (sbq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_done: got done=1, want no run pending");
                end else begin
                    e = sbq.pop_front();
                    chkw("sb_cycles", WV_W'(bus.cycles), WV_W'(e.cyc));
                    chkw("sb_run_len", WV_W'(run_cnt), WV_W'(e.cyc));
                    chkw("sb_check_to_done", WV_W'(since_run), WV_W'(2));
                    chkb("sb_timeout", bus.timeout, e.to);
                    chkb("sb_pass", bus.pass, e.ps);
                    chkw("sb_mismatch", WV_W'(bus.mismatch), WV_W'(e.mm));
                    chkw("sb_watch_val", bus.watch_val, e.wv);
                end
            end
            done_q = bus.done;
        end
    end

    task automatic do_run(input bit seq_chk, input bit poke);
        exp_t e;
        bit   seen;
        e = model();
        sbq.push_back(e);
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        if (seq_chk) begin
            chkb("rc1_core_rst_n", bus.core_rst_n, 1'b0);
            chkb("rc1_core_run", bus.core_run, 1'b0);
            chkb("rc1_busy", bus.busy, 1'b1);
        end
        @(negedge clk);
        if (seq_chk) begin
            chkb("rc2_core_rst_n", bus.core_rst_n, 1'b0);
            chkb("rc2_done", bus.done, 1'b0);
            chkw("rc2_cycles", WV_W'(bus.cycles), '0);
            chkw("rc2_watch_val", bus.watch_val, '0);
        end
        @(negedge clk);
        if (seq_chk) begin
            chkb("run1_core_run", bus.core_run, 1'b1);
            chkb("run1_core_rst_n", bus.core_rst_n, 1'b1);
        end
        if (poke) begin
            repeat (3) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk); bus.start = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 6000 && !seen; k++) begin
            if (bus.done) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL run_wait: got no done within budget, want done");
            sbq.delete();
            rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        logic [XLEN-1:0] p;
        bus.start = 1'b0; bus.cycle_limit = '0; bus.watch_addr = '0;
        bus.expect_data = '0; bus.expect_mask = '0;
        tr_clear(); tr_add(32'h0, 1'b0, 5'd0, 32'h0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chkb("idle_busy", bus.busy, 1'b0);
        chkb("idle_core_rst_n", bus.core_rst_n, 1'b0);

        // Normal halt: addi x1,x0,5 then jal x0,0.
        tr_clear();
        tr_add(32'h0, 1'b1, 5'd1, 32'h5);
        tr_add(32'h4, 1'b0, 5'd0, 32'h0);
        bus.cycle_limit = 16'd100;
        set_ch(0, 5'd1, 32'h5);
        bus.expect_mask = 4'b0001;
        do_run(1'b1, 1'b0);
        chkb("halt_pass", bus.pass, 1'b1);
        chkb("halt_timeout", bus.timeout, 1'b0);
        chkw("halt_cycles", WV_W'(bus.cycles), WV_W'(2 + HS));
        chkw("halt_x1", WV_W'(bus.watch_val[31:0]), WV_W'(32'h5));
        repeat (3) @(negedge clk);
        chkb("halt_done_held", bus.done, 1'b1);
        chkb("halt_pass_held", bus.pass, 1'b1);

        // Mismatch, started from DONE.
        set_ch(0, 5'd1, 32'h6);
        do_run(1'b1, 1'b0);
        chkb("mm_pass", bus.pass, 1'b0);
        chkw("mm_mask", WV_W'(bus.mismatch), WV_W'(4'b0001));

        // Identical rerun gives the original verdict.
        set_ch(0, 5'd1, 32'h5);
        do_run(1'b0, 1'b0);
        chkb("rerun_pass", bus.pass, 1'b1);
        chkw("rerun_cycles", WV_W'(bus.cycles), WV_W'(4));

        // Timeout on a two-PC loop; a start pulse while busy must be ignored.
        tr_clear();
        for (int i = 0; i < 60; i++)
            tr_add((i % 2 == 1) ? 32'h4 : 32'h0, (i % 3 == 0), 5'd2, XLEN'(i));
        bus.cycle_limit = 16'd20;
        set_ch(0, 5'd2, 32'd18);
        do_run(1'b0, 1'b1);
        chkb("to_timeout", bus.timeout, 1'b1);
        chkb("to_pass", bus.pass, 1'b0);
        chkw("to_cycles", WV_W'(bus.cycles), WV_W'(20));
        chkw("to_x2", WV_W'(bus.watch_val[31:0]), WV_W'(18));

        // Halt and limit in the same cycle; x0 channel ignores writes; shared index.
        tr_clear();
        tr_add(32'h0, 1'b1, 5'd0, 32'hdeadbeef);
        tr_add(32'h4, 1'b1, 5'd1, 32'h5);
        tr_add(32'h4, 1'b1, 5'd0, 32'h1234);
        bus.cycle_limit = 16'd4;
        set_ch(0, 5'd1, 32'h5); set_ch(1, 5'd0, 32'h0);
        set_ch(2, 5'd1, 32'h5); set_ch(3, 5'd3, 32'h0);
        bus.expect_mask = 4'b0111;
        do_run(1'b0, 1'b0);
        chkb("tie_timeout", bus.timeout, 1'b0);
        chkb("tie_pass", bus.pass, 1'b1);
        chkw("tie_cycles", WV_W'(bus.cycles), WV_W'(4));
        chkw("tie_x0", WV_W'(bus.watch_val[63:32]), '0);

        // Asynchronous reset in the middle of an unlimited run.
        tr_clear();
        for (int i = 0; i < 40; i++) tr_add((i % 2 == 1) ? 32'h8 : 32'h0, 1'b1, 5'd1, XLEN'(i + 1));
        bus.cycle_limit = '0;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        repeat (8) @(negedge clk);
        chkb("mid_core_rst_n_before", bus.core_rst_n, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        tr_clear();
        tr_add(32'h0, 1'b1, 5'd1, 32'h5);
        tr_add(32'h4, 1'b0, 5'd0, 32'h0);
        bus.cycle_limit = 16'd100;
        set_ch(0, 5'd1, 32'h5); set_ch(1, 5'd0, 32'h0);
        set_ch(2, 5'd0, 32'h0); set_ch(3, 5'd0, 32'h0);
        bus.expect_mask = 4'b0001;
        do_run(1'b1, 1'b0);
        chkb("after_rst_pass", bus.pass, 1'b1);

        // Random traces, watch sets and budgets.
        for (int r = 0; r < 30; r++) begin
            tr_clear();
            p = '0;
            for (int i = 0; i < int'($urandom_range(3, 40)); i++) begin
                tr_add(p, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 5)), $urandom);
                case ($urandom_range(0, 9))
                    0, 1:    p = p;
                    8, 9:    p = XLEN'($urandom_range(0, 63)) << 2;
                    default: p = p + 32'h4;
                endcase
            end
            bus.cycle_limit = ($urandom_range(0, 3) == 0) ? '0 : CNT_W'($urandom_range(1, 45));
            for (int c = 0; c < NWATCH; c++) set_ch(c, 5'($urandom_range(0, 5)), 32'h0);
            bus.expect_mask = NWATCH'($urandom_range(0, 15));
            e = model();
            for (int c = 0; c < NWATCH; c++)
                bus.expect_data[XLEN*c +: XLEN] = ($urandom_range(0, 3) != 0) ? e.wv[XLEN*c +: XLEN] : $urandom;
            do_run(1'b0, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
